// File: rtl/multicycle_decoder.sv
// Multicycle ARM control unit: Moore FSM sequencing each instruction from the
// registered Op/Funct/Rd fields and driving datapath selects and write enables.
`timescale 1ns/1ps

module multicycle_decoder #(
    parameter int ALUCTRL_W     = 2,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 mem_ready,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 Branch,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 NoWrite,
    output logic                 Illegal,
    output logic                 InstrDone,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_MOV = ALUCTRL_W'(5);
    localparam bit                   WIDE_ALU = (ALUCTRL_W == 3);

    state_t                 state;
    state_t                 state_next;
    logic                   ready;
    logic [ALUCTRL_W-1:0]   dp_alu;
    logic                   dp_nowrite;
    logic                   dp_arith;
    logic                   dp_supported;
    logic [1:0]             dp_flagw;

    // Without the handshake, memory is assumed to complete every access at once.
    assign ready = mem_ready | ~MEM_HANDSHAKE;

    // NOTE: sequential state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        dp_alu       = ALU_ADD;
        dp_nowrite   = 1'b1;
        dp_arith     = 1'b0;
        dp_supported = 1'b0;
        case (Funct[4:1])
            4'b0100: begin dp_alu = ALU_ADD; dp_nowrite = 1'b0; dp_arith = 1'b1; dp_supported = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB; dp_nowrite = 1'b0; dp_arith = 1'b1; dp_supported = 1'b1; end
            4'b0000: begin dp_alu = ALU_AND; dp_nowrite = 1'b0; dp_supported = 1'b1; end
            4'b1100: begin dp_alu = ALU_ORR; dp_nowrite = 1'b0; dp_supported = 1'b1; end
            4'b1010: begin dp_alu = ALU_SUB; dp_nowrite = 1'b1; dp_arith = 1'b1; dp_supported = 1'b1; end
            4'b0001: if (WIDE_ALU) begin dp_alu = ALU_EOR; dp_nowrite = 1'b0; dp_supported = 1'b1; end
            4'b1101: if (WIDE_ALU) begin dp_alu = ALU_MOV; dp_nowrite = 1'b0; dp_supported = 1'b1; end
            default: ;
        endcase
        dp_flagw = dp_supported ? {Funct[0], Funct[0] & dp_arith} : 2'b00;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = ready ? MEMWB : MEMRD;
            MEMWR:  state_next = ready ? FETCH : MEMWR;
            EXECR,
            EXECI:  state_next = dp_nowrite ? FETCH : ALUWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        NextPC     = 1'b0;
        Branch     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        Illegal    = 1'b0;
        InstrDone  = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                NextPC    = ready;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                Illegal   = (Op == 2'b11);
                InstrDone = (Op == 2'b11);
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = ready;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = dp_alu;
                FlagW      = dp_flagw;
                NoWrite    = dp_nowrite;
                InstrDone  = dp_nowrite;
            end
            ALUWB: begin
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign PCS    = Branch | (RegW & (Rd == 4'd15));
    assign State  = state;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Self-checking bench: two decoder configurations compared cycle by cycle
// against instruction-level expected state sequences and per-state output rules.
`timescale 1ns/1ps

module tb_multicycle_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic       mem_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcs, next_pc, branch, reg_w, mem_w, ir_write, adr_src, alu_src_a;
        logic [1:0] alu_src_b, result_src, imm_src, reg_src;
        logic [2:0] alu_ctrl;
        logic [1:0] flag_w;
        logic       no_write, illegal, instr_done;
        logic [3:0] state;
    } outs_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
    } step_t;

    // Instance a: default configuration (2-bit ALU, handshake on).
    logic a_PCS, a_NextPC, a_Branch, a_RegW, a_MemW, a_IRWrite, a_AdrSrc, a_ALUSrcA;
    logic [1:0] a_ALUSrcB, a_ResultSrc, a_ImmSrc, a_RegSrc, a_ALUControl, a_FlagW;
    logic a_NoWrite, a_Illegal, a_InstrDone;
    logic [3:0] a_State;

    // Instance b: 3-bit ALU, handshake off, mem_ready tied low.
    logic b_PCS, b_NextPC, b_Branch, b_RegW, b_MemW, b_IRWrite, b_AdrSrc, b_ALUSrcA;
    logic [1:0] b_ALUSrcB, b_ResultSrc, b_ImmSrc, b_RegSrc, b_FlagW;
    logic [2:0] b_ALUControl;
    logic b_NoWrite, b_Illegal, b_InstrDone;
    logic [3:0] b_State;

    multicycle_decoder #(.ALUCTRL_W(2), .MEM_HANDSHAKE(1'b1)) dut_a (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(mem_ready),
        .PCS(a_PCS), .NextPC(a_NextPC), .Branch(a_Branch), .RegW(a_RegW), .MemW(a_MemW),
        .IRWrite(a_IRWrite), .AdrSrc(a_AdrSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
        .ResultSrc(a_ResultSrc), .ImmSrc(a_ImmSrc), .RegSrc(a_RegSrc), .ALUControl(a_ALUControl),
        .FlagW(a_FlagW), .NoWrite(a_NoWrite), .Illegal(a_Illegal), .InstrDone(a_InstrDone),
        .State(a_State)
    );

    multicycle_decoder #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .mem_ready(1'b0),
        .PCS(b_PCS), .NextPC(b_NextPC), .Branch(b_Branch), .RegW(b_RegW), .MemW(b_MemW),
        .IRWrite(b_IRWrite), .AdrSrc(b_AdrSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .ResultSrc(b_ResultSrc), .ImmSrc(b_ImmSrc), .RegSrc(b_RegSrc), .ALUControl(b_ALUControl),
        .FlagW(b_FlagW), .NoWrite(b_NoWrite), .Illegal(b_Illegal), .InstrDone(b_InstrDone),
        .State(b_State)
    );

    wire [27:0] a_vec = {a_PCS, a_NextPC, a_Branch, a_RegW, a_MemW, a_IRWrite, a_AdrSrc, a_ALUSrcA,
                         a_ALUSrcB, a_ResultSrc, a_ImmSrc, a_RegSrc, 1'b0, a_ALUControl, a_FlagW,
                         a_NoWrite, a_Illegal, a_InstrDone, a_State};
    wire [27:0] b_vec = {b_PCS, b_NextPC, b_Branch, b_RegW, b_MemW, b_IRWrite, b_AdrSrc, b_ALUSrcA,
                         b_ALUSrcB, b_ResultSrc, b_ImmSrc, b_RegSrc, b_ALUControl, b_FlagW,
                         b_NoWrite, b_Illegal, b_InstrDone, b_State};

    // Data-processing command table: ALU code, writeback suppression and flag enables.
    function automatic void dp_ref(input logic [5:0] f, input bit w3,
                                   output logic [2:0] alu, output bit nw, output logic [1:0] fw);
        bit arith = 0;
        bit ok = 0;
        alu = 3'd0;
        nw  = 1;
        case (f[4:1])
            4'b0100: begin alu = 3'd0; nw = 0; arith = 1; ok = 1; end
            4'b0010: begin alu = 3'd1; nw = 0; arith = 1; ok = 1; end
            4'b0000: begin alu = 3'd2; nw = 0; ok = 1; end
            4'b1100: begin alu = 3'd3; nw = 0; ok = 1; end
            4'b1010: begin alu = 3'd1; nw = 1; arith = 1; ok = 1; end
            4'b0001: if (w3) begin alu = 3'd4; nw = 0; ok = 1; end
            4'b1101: if (w3) begin alu = 3'd5; nw = 0; ok = 1; end
            default: ;
        endcase
        fw = ok ? {f[0], f[0] & arith} : 2'b00;
    endfunction

    function automatic outs_t ref_out(input int st, input bit rdy, input logic [1:0] op,
                                      input logic [5:0] f, input logic [3:0] rd, input bit w3);
        outs_t o = '0;
        logic [2:0] alu;
        bit nw;
        logic [1:0] fw;
        o.state   = 4'(st);
        o.imm_src = op;
        o.reg_src = {op == 2'b01, op == 2'b10};
        case (st)
            0: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
                     o.ir_write = rdy; o.next_pc = rdy; end
            1: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
                     o.illegal = (op == 2'b11); o.instr_done = (op == 2'b11); end
            2: o.alu_src_b = 2'b01;
            3: o.adr_src = 1;
            4: begin o.result_src = 2'b01; o.reg_w = 1; o.instr_done = 1; end
            5: begin o.adr_src = 1; o.mem_w = 1; o.instr_done = rdy; end
            6, 7: begin
                dp_ref(f, w3, alu, nw, fw);
                o.alu_src_b  = (st == 7) ? 2'b01 : 2'b00;
                o.alu_ctrl   = alu;
                o.flag_w     = fw;
                o.no_write   = nw;
                o.instr_done = nw;
            end
            8: begin o.reg_w = 1; o.instr_done = 1; end
            9: begin o.alu_src_b = 2'b01; o.result_src = 2'b10; o.branch = 1; o.instr_done = 1; end
            default: ;
        endcase
        o.pcs = o.branch | (o.reg_w & (rd == 4'd15));
        return o;
    endfunction

    // Runs one instruction on instance a (inst_b=0) or b (inst_b=1); fw/mw are the
    // wait cycles in FETCH and in the memory access. abort_at >= 0 asserts reset at that step.
    task automatic run_instr(input bit inst_b, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input int fw, input int mw,
                             input string name, input int abort_at);
        step_t seq[$];
        logic [2:0] alu;
        bit nw;
        logic [1:0] flw;
        outs_t got, exp;
        int fwait = inst_b ? 0 : fw;
        int mwait = inst_b ? 0 : mw;
        for (int k = 0; k < fwait; k++) seq.push_back({4'd0, 1'b0});
        seq.push_back({4'd0, 1'b1});
        seq.push_back({4'd1, 1'b1});
        case (op)
            2'b01: begin
                seq.push_back({4'd2, 1'b1});
                if (f[0]) begin
                    for (int k = 0; k < mwait; k++) seq.push_back({4'd3, 1'b0});
                    seq.push_back({4'd3, 1'b1});
                    seq.push_back({4'd4, 1'b1});
                end else begin
                    for (int k = 0; k < mwait; k++) seq.push_back({4'd5, 1'b0});
                    seq.push_back({4'd5, 1'b1});
                end
            end
            2'b00: begin
                seq.push_back({f[5] ? 4'd7 : 4'd6, 1'b1});
                dp_ref(f, inst_b, alu, nw, flw);
                if (!nw) seq.push_back({4'd8, 1'b1});
            end
            2'b10: seq.push_back({4'd9, 1'b1});
            default: ;
        endcase
        foreach (seq[i]) begin
            @(negedge clk);
            reset     = 1'b0;
            Op        = op;
            Funct     = f;
            Rd        = rd;
            mem_ready = inst_b ? 1'($urandom) : seq[i].rdy;
            #2;
            exp = ref_out(int'(seq[i].st), inst_b ? 1'b1 : seq[i].rdy, op, f, rd, inst_b);
            got = inst_b ? outs_t'(b_vec) : outs_t'(a_vec);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s step %0d: got %h required %h", name, i, got, exp);
            end
            if (i == abort_at) begin
                #1 reset = 1'b1;
                #1;
                exp = ref_out(0, seq[i].rdy, op, f, rd, inst_b);
                got = inst_b ? outs_t'(b_vec) : outs_t'(a_vec);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s async_reset: got %h required %h", name, got, exp);
                end
                return;
            end
        end
    endtask

    // Leaves reset asserted; the next run_instr releases it on its first step.
    task automatic do_reset();
        outs_t ea, eb;
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
        ea = ref_out(0, 1'b1, 2'b00, 6'd0, 4'd0, 1'b0);
        eb = ref_out(0, 1'b1, 2'b00, 6'd0, 4'd0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #2;
            checks += 2;
            if (outs_t'(a_vec) !== ea) begin
                errors++;
                $display("FAIL reset_a cycle %0d: got %h required %h", c, a_vec, ea);
            end
            if (outs_t'(b_vec) !== eb) begin
                errors++;
                $display("FAIL reset_b cycle %0d: got %h required %h", c, b_vec, eb);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_add_reg();
        run_instr(0, 2'b00, 6'b001000, 4'd3, 0, 0, "add_reg", -1);
        run_instr(0, 2'b00, 6'b101001, 4'd15, 1, 0, "addi_s_pc", -1);
    endtask

    task automatic test_ldr_wait();
        run_instr(0, 2'b01, 6'b000001, 4'd5, 0, 2, "ldr_wait", -1);
        run_instr(0, 2'b01, 6'b011001, 4'd15, 2, 0, "ldr_pc_fetch_wait", -1);
    endtask

    task automatic test_str_branch();
        run_instr(0, 2'b01, 6'b000000, 4'd15, 0, 0, "str_pc", -1);
        run_instr(0, 2'b01, 6'b011000, 4'd2, 0, 3, "str_wait", -1);
        run_instr(0, 2'b10, 6'b110110, 4'd7, 0, 0, "branch", -1);
    endtask

    task automatic test_cmp();
        run_instr(0, 2'b00, 6'b010101, 4'd9, 0, 0, "cmp_s", -1);
        run_instr(0, 2'b00, 6'b111111, 4'd1, 0, 0, "unsupported_dp", -1);
    endtask

    task automatic test_eor_illegal();
        run_instr(0, 2'b00, 6'b000010, 4'd4, 0, 0, "eor_w2", -1);
        run_instr(0, 2'b11, 6'b101010, 4'd6, 0, 0, "illegal", -1);
        run_instr(0, 2'b00, 6'b011000, 4'd1, 0, 0, "orr_after_illegal", -1);
    endtask

    task automatic test_reset_mid_store();
        run_instr(0, 2'b01, 6'b000000, 4'd8, 0, 2, "str_reset", 3);
        run_instr(0, 2'b00, 6'b000000, 4'd3, 0, 0, "and_after_reset", -1);
    endtask

    task automatic test_no_handshake();
        run_instr(1, 2'b01, 6'b000001, 4'd5, 0, 0, "ldr_no_handshake", -1);
        run_instr(1, 2'b00, 6'b000010, 4'd4, 0, 0, "eor_w3", -1);
        run_instr(1, 2'b00, 6'b111011, 4'd15, 0, 0, "movi_s_w3", -1);
        run_instr(1, 2'b01, 6'b000000, 4'd2, 0, 0, "str_no_handshake", -1);
    endtask

    task automatic test_back_to_back(input bit inst_b, input int count);
        for (int n = 0; n < count; n++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [5:0] f  = 6'($urandom);
            logic [3:0] rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            int fw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            int mw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            run_instr(inst_b, op, f, rd, fw, mw, inst_b ? "random_b" : "random_a", -1);
        end
    endtask

    initial begin
        test_reset();
        test_add_reg();
        test_ldr_wait();
        test_str_branch();
        test_cmp();
        test_eor_illegal();
        test_reset_mid_store();
        do_reset();
        test_no_handshake();
        do_reset();
        test_back_to_back(1'b0, 80);
        do_reset();
        test_back_to_back(1'b1, 60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_decoder.md
# multicycle_decoder

Control unit for the multicycle ARM core, replacing the single-cycle combinational decoder. From the registered instruction fields (Op, Funct, Rd) it sequences each instruction through a Moore state machine and drives datapath selects, register/memory/PC write enables and ALU control. It supports an optional memory-ready handshake for variable-latency memory and a selectable ALU control width. It sits between the instruction register and the conditional logic/datapath.

## Interface
- ALUCTRL_W, default 2: ALUControl width. Legal values are 2 (ADD/SUB/AND/ORR/CMP) or 3 (adds EOR and MOV).
- MEM_HANDSHAKE, default 1: 1 means FETCH/MEMRD/MEMWR wait for mem_ready; 0 means mem_ready is ignored and treated as 1.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- Op  in  2  instruction bits [27:26], held stable by the IR after FETCH.
- Funct  in  6  instruction bits [25:20].
- Rd  in  4  destination register.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCS  out  1  Branch | (RegW & Rd==15).
- NextPC  out  1  PC += 4 write enable.
- Branch  out  1  branch-target PC write request; gated externally by the condition.
- RegW, MemW, IRWrite  out  1 each  write enables.
- AdrSrc  out  1  0 = PC address, 1 = ALU result address.
- ALUSrcA  out  1  0 = register, 1 = PC.
- ALUSrcB  out  2  00 = register, 01 = immediate, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- ImmSrc  out  2  equal to Op.
- RegSrc  out  2  RegSrc[0] = (Op==10), RegSrc[1] = (Op==01).
- ALUControl  out  ALUCTRL_W  ALU operation.
- FlagW  out  2  flag write enables {NZ, CV}.
- NoWrite  out  1  DP instruction without register writeback.
- Illegal  out  1  one-cycle pulse on an undefined Op.
- InstrDone  out  1  one-cycle pulse in the final state of every instruction.
- State  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE when ready.
  - DECODE: Op=01 → MEMADR; Op=00 & Funct[5]=0 → EXECR; Op=00 & Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH with Illegal=1.
  - MEMADR → MEMRD if Funct[0], else MEMWR.
  - MEMRD → MEMWB when ready. MEMWR → FETCH when ready.
  - EXECR/EXECI → FETCH if NoWrite, else ALUWB.
  - MEMWB, ALUWB, BRANCH → FETCH.
- "Ready" means mem_ready | ~MEM_HANDSHAKE.
- Per-state outputs (anything unlisted is 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU ADD. IRWrite and NextPC are asserted only in the ready cycle.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD.
  - MEMADR: ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemW=1 held for every wait cycle.
  - MEMWB: ResultSrc=01, RegW.
  - EXECR: ALUSrcB=00, DP op.
  - EXECI: ALUSrcB=01, DP op.
  - ALUWB: RegW.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch, ADD.
- DP op decoding, cmd = Funct[4:1]:
  - 0100 ADD → 0.
  - 0010 SUB → 1.
  - 0000 AND → 2.
  - 1100 ORR → 3.
  - 1010 CMP → 1 with NoWrite=1.
  - When ALUCTRL_W=3 only: 0001 EOR → 4, 1101 MOV → 5.
  - Any other cmd (including EOR/MOV at width 2): ALUControl=0, FlagW=00, NoWrite=1.
- FlagW is valid only in EXECR/EXECI. FlagW[1] = Funct[0]; FlagW[0] = Funct[0] & (op is ADD, SUB or CMP). FlagW is 00 in all other states.
- NoWrite is driven in EXECR/EXECI only.

## Timing
- Reset: State=FETCH. Every registered output is 0. Outputs are Moore functions of State plus the combinational fields Op, Funct, Rd and mem_ready, so during reset they take FETCH values with IRWrite and NextPC gated by ready.
- Reset asserted mid-instruction returns to FETCH asynchronously. No partial write enable survives after reset is released.
- Cycles with zero wait states:
  - B: 3.
  - CMP or unsupported DP: 3.
  - DP with writeback: 4.
  - STR: 4.
  - LDR: 5.
  - Op=11: 2.
- Each wait cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) adds one cycle. During a wait the state and all outputs are held; enables gated by ready stay low.
- InstrDone is high in MEMWB, MEMWR (ready cycle), ALUWB, BRANCH, EXECR/EXECI when NoWrite, and DECODE when Op=11.

## Test plan
- ADD reg (Op=00, Funct=001000, Rd=3), mem_ready=1 → states 0,1,6,8,0; RegW=1 only in state 8; ALUControl=0, FlagW=00, PCS=0.
- LDR (Op=01, Funct=000001) with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; RegW=1 only in state 4, with ResultSrc=01.
- STR with Rd=15 (Op=01, Funct=000000) → MemW=1 in state 5, RegW=0 throughout, PCS=0; B (Op=10) → Branch=1 and PCS=1 in state 9.
- CMP with S (Funct=010101) → states 0,1,6,0; ALUControl=1, FlagW=11, NoWrite=1, InstrDone in state 6, RegW never asserted.
- EOR (Funct=000010): at ALUCTRL_W=3 ALUControl=100 and ALUWB is visited; at ALUCTRL_W=2 ALUControl=00, NoWrite=1, ALUWB is skipped. Op=11 → Illegal pulse in DECODE, then FETCH.
- Assert reset during MEMWR with MemW=1 → State=0 and MemW=0 in the same cycle; with MEM_HANDSHAKE=0 and mem_ready tied 0, LDR still completes in 5 cycles.
